// File: rtl/aes_pkg.sv
// Shared AES definitions: state width, byte count, state type, FSM encoding
// and the forward/inverse S-box tables with byte lookup helpers.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTES   = 16;

  typedef logic [AES_STATE_W-1:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } isb_state_e;

  // Entry 0 sits in the top byte, so entry b lives at bit 8*(255-b).
  localparam logic [2047:0] SBOX_FWD_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] SBOX_INV_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return SBOX_FWD_TBL[idx +: 8];
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return SBOX_INV_TBL[idx +: 8];
  endfunction

endpackage

// File: rtl/sbox.sv
// Bank of NUM parallel AES S-boxes; EN=1 forward, EN=0 inverse.
// Ports: i_bytes / o_bytes, byte k at bits [8k+7:8k].
module sbox
  import aes_pkg::*;
#(
  parameter int NUM = 1,
  parameter bit EN  = 1'b1
) (
  input  logic [8*NUM-1:0] i_bytes,
  output logic [8*NUM-1:0] o_bytes
);

  for (genvar g = 0; g < NUM; g++) begin : g_lane
    if (EN) begin : g_fwd
      assign o_bytes[8*g +: 8] = sbox_fwd(i_bytes[8*g +: 8]);
    end else begin : g_inv
      assign o_bytes[8*g +: 8] = sbox_inv(i_bytes[8*g +: 8]);
    end
  end

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: LANES bytes per cycle through one shared
// inverse S-box bank. Ports: clk, rst_n (async low), in_valid/in_ready/
// in_state accept side, out_valid/out_ready/out_state result side, busy.
module inv_sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int CHUNKS = AES_BYTES / LANES;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int SEL_W  = 8 * LANES;
  localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 ||
        LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  isb_state_e       r_fsm;
  isb_state_e       w_fsm_n;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_n;
  aes_state_t       r_state;
  aes_state_t       w_state_n;
  logic [6:0]       w_base;
  logic [SEL_W-1:0] w_sel;
  logic [SEL_W-1:0] w_sub;

  // Bit offset of the chunk being substituted this cycle.
  assign w_base = 7'(int'(r_cnt) * SEL_W);
  assign w_sel  = r_state[w_base +: SEL_W];

  sbox #(
    .NUM (LANES),
    .EN  (1'b0)
  ) u_inv_sbox (
    .i_bytes (w_sel),
    .o_bytes (w_sub)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= IDLE;
      r_cnt   <= '0;
      r_state <= '0;
    end else begin
      r_fsm   <= w_fsm_n;
      r_cnt   <= w_cnt_n;
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_fsm_n   = r_fsm;
    w_cnt_n   = r_cnt;
    w_state_n = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (r_fsm)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_state_n = in_state;
          w_cnt_n   = '0;
          w_fsm_n   = BUSY;
        end
      end
      BUSY: begin
        w_state_n[w_base +: SEL_W] = w_sub;
        if (r_cnt == LAST) begin
          w_cnt_n = '0;
          w_fsm_n = DONE;
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_fsm_n = IDLE;
        end
      end
      default: begin
        w_fsm_n = IDLE;
      end
    endcase
  end

  assign out_state = r_state;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Directed bench for inv_sub_bytes_iter: LANES=1/4/16 instances,
// handshake, backpressure, async reset and forward/inverse round trip.
module tb_inv_sub_bytes_iter;

  logic         clk;
  logic         rst_n;
  logic [2:0]   in_valid_v;
  logic [127:0] in_state;
  logic         out_ready;
  logic [2:0]   in_ready_v;
  logic [2:0]   out_valid_v;
  logic [2:0]   busy_v;
  logic [127:0] out_state_a [3];
  logic [127:0] fw_in;
  logic [127:0] fw_out;

  int n_checks;
  int n_errors;
  int chunks_tab [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  inv_sub_bytes_iter #(.LANES(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_v[0]),
    .in_ready  (in_ready_v[0]),
    .in_state  (in_state),
    .out_valid (out_valid_v[0]),
    .out_ready (out_ready),
    .out_state (out_state_a[0]),
    .busy      (busy_v[0])
  );

  inv_sub_bytes_iter #(.LANES(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_v[1]),
    .in_ready  (in_ready_v[1]),
    .in_state  (in_state),
    .out_valid (out_valid_v[1]),
    .out_ready (out_ready),
    .out_state (out_state_a[1]),
    .busy      (busy_v[1])
  );

  inv_sub_bytes_iter #(.LANES(16)) u_dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_v[2]),
    .in_ready  (in_ready_v[2]),
    .in_state  (in_state),
    .out_valid (out_valid_v[2]),
    .out_ready (out_ready),
    .out_state (out_state_a[2]),
    .busy      (busy_v[2])
  );

  sbox #(.NUM(16), .EN(1'b1)) u_fwd (
    .i_bytes (fw_in),
    .o_bytes (fw_out)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offer one block to instance idx, wait for out_valid, return the
  // result and the number of edges from accept to out_valid.
  task automatic send(input int idx, input logic [127:0] data,
                      output logic [127:0] res, output int lat);
    in_valid_v[idx] = 1'b1;
    in_state = data;
    chk1("accept_ready", in_ready_v[idx], 1'b1);
    @(negedge clk);
    in_valid_v[idx] = 1'b0;
    lat = 0;
    while (!out_valid_v[idx] && lat < 64) begin
      chk1("busy_in_ready", in_ready_v[idx], 1'b0);
      chk1("busy_flag", busy_v[idx], 1'b1);
      @(negedge clk);
      lat++;
    end
    if (lat >= 64) begin
      n_checks++;
      n_errors++;
      $error("FAIL timeout observed=no_out_valid expected=out_valid");
    end
    chk1("done_in_ready", in_ready_v[idx], 1'b0);
    chk1("done_busy", busy_v[idx], 1'b1);
    res = out_state_a[idx];
  endtask

  initial begin
    logic [127:0] r;
    logic [127:0] orig;
    logic [127:0] ct;
    int lat;
    n_checks = 0;
    n_errors = 0;
    chunks_tab = '{16, 4, 1};
    rst_n = 1'b0;
    in_valid_v = '0;
    in_state = '0;
    out_ready = 1'b1;
    fw_in = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("rst_in_ready", in_ready_v[1], 1'b1);
    chk1("rst_out_valid", out_valid_v[1], 1'b0);
    chkw("rst_out_state", out_state_a[1], 128'h0);
    chk1("rst_busy", busy_v[1], 1'b0);

    send(1, {16{8'h63}}, r, lat);
    chki("lat_l4", lat, 4);
    chkw("inv_63", r, 128'h0);
    @(negedge clk);
    chk1("post_out_valid", out_valid_v[1], 1'b0);
    chk1("post_in_ready", in_ready_v[1], 1'b1);
    chk1("post_busy", busy_v[1], 1'b0);

    send(1, {4{32'h5d15cd16}}, r, lat);
    chkw("inv_pattern", r, {4{32'h8d2f80ff}});
    @(negedge clk);
    chkw("hold_last", out_state_a[1], {4{32'h8d2f80ff}});

    send(1, 128'h84, r, lat);
    chkw("inv_84_00", r, {{15{8'h52}}, 8'h4f});
    @(negedge clk);

    out_ready = 1'b0;
    send(1, {16{8'hcd}}, r, lat);
    chkw("bp_result", r, {16{8'h80}});
    for (int i = 0; i < 10; i++) begin
      in_valid_v[1] = 1'b1;
      in_state = {16{8'h84}};
      @(negedge clk);
      chk1("bp_out_valid", out_valid_v[1], 1'b1);
      chkw("bp_stable", out_state_a[1], {16{8'h80}});
      chk1("bp_in_ready", in_ready_v[1], 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk1("rel_out_valid", out_valid_v[1], 1'b0);
    chk1("rel_in_ready", in_ready_v[1], 1'b1);
    chk1("rel_no_accept", busy_v[1], 1'b0);
    in_valid_v[1] = 1'b0;
    send(1, {16{8'h84}}, r, lat);
    chkw("second_block", r, {16{8'h4f}});
    @(negedge clk);

    in_valid_v[1] = 1'b1;
    in_state = {16{8'h16}};
    @(negedge clk);
    in_valid_v[1] = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk1("mid_rst_in_ready", in_ready_v[1], 1'b1);
    chk1("mid_rst_out_valid", out_valid_v[1], 1'b0);
    chkw("mid_rst_out_state", out_state_a[1], 128'h0);
    chk1("mid_rst_busy", busy_v[1], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(1, {16{8'h7c}}, r, lat);
    chkw("after_abort", r, {16{8'h01}});
    chki("after_abort_lat", lat, 4);
    @(negedge clk);

    for (int i = 0; i < 200; i++) begin
      orig = {$urandom(), $urandom(), $urandom(), $urandom()};
      fw_in = orig;
      #1;
      ct = fw_out;
      for (int k = 0; k < 3; k++) begin
        send(k, ct, r, lat);
        chki("rt_latency", lat, chunks_tab[k]);
        chkw("rt_data", r, orig);
        @(negedge clk);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inv_sub_bytes_iter.md
Name: inv_sub_bytes_iter

Overview:
Iterative AES InvSubBytes engine for the decryption datapath. It is the inverse counterpart to the forward S-box substitution used on the encrypt side. It accepts a 128-bit state over a valid/ready handshake and substitutes LANES bytes per cycle through one shared inverse S-box bank. It returns the full 128-bit result over a second valid/ready handshake, trading latency for S-box area in the decrypt round loop.

Parameters:
LANES, 4, bytes substituted per cycle; legal values are 1, 2, 4, 8 and 16 (must divide 16); any other value is an elaboration error.
CHUNKS, 16/LANES, derived local parameter; number of processing cycles per block.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input state valid
in_ready  output  1  engine can accept a state
in_state  input  128  ciphertext-side state; byte k occupies bits [8k+7:8k]
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_state  output  128  substituted state; same byte mapping as in_state
busy  output  1  high in BUSY or DONE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, chunk counter=0, state register=0, in_ready=1, out_valid=0, out_state=0, busy=0. Reset takes effect immediately at any point, including mid-block; the in-flight block is discarded and no partial result is ever presented.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register in_state, clear counter, go to BUSY.
  - Without in_valid, stay in IDLE; the state register is held.
- BUSY:
  - in_ready=0.
  - Each cycle the counter c selects bytes c*LANES .. c*LANES+LANES-1.
  - Those bytes pass combinationally through the inverse S-box bank and are written back in place at the clock edge; all other bytes are unchanged.
  - c increments each cycle. When c==CHUNKS-1 is written, c returns to 0 and the FSM goes to DONE.
  - in_valid is ignored.
- DONE:
  - out_valid=1, out_state=register, in_ready=0.
  - Hold until out_ready=1. On out_valid&&out_ready, go to IDLE; out_valid falls the next cycle.
  - out_state is stable while out_valid=1 and out_ready=0.
  - After the handshake, out_state keeps its last value.
- Latency: a block accepted at edge T has out_valid high after edge T+CHUNKS. With LANES=4, that is 4 cycles.
- Throughput: one block per CHUNKS+2 cycles when out_ready is tied high.
- No back-to-back accept in DONE: in_ready stays 0 until IDLE, even if out_ready and in_valid are both high in the same cycle.
- LANES=16: BUSY lasts exactly 1 cycle; the counter is degenerate and stays at 0.
- Substitution is the standard AES inverse S-box, per byte, with no key or mixing.
- out_valid, in_ready and busy are decoded from FSM state only, with no combinational path from in_valid or out_ready.

Decomposition:
- Shared package aes_pkg:
  - AES_STATE_W=128 and AES_BYTES=16.
  - Typedef aes_state_t (logic [127:0]).
  - FSM enum (IDLE, BUSY, DONE).
- One sub-module: the existing sbox instantiated with NUM=LANES, EN=0 (inverse direction) as the shared substitution bank.
- The byte-select mux and write-back live in this module.

Test Plan:
1. Reset, then in_state = 16 copies of 0x63, LANES=4, out_ready=1 -> out_valid high 4 cycles after accept; out_state = 128'h0; in_ready=0 throughout BUSY/DONE.
2. in_state bytes repeating {0x16,0xcd,0x15,0x5d} from byte 0 upward -> out_state bytes repeating {0xff,0x80,0x2f,0x8d}. Separately, byte 0=0x84 and all other bytes 0x00 -> byte 0=0x4f, all other bytes 0x52.
3. Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_state is stable, in_ready=0, and a new in_valid is not accepted; release -> IDLE the next cycle, and the second block is accepted afterwards with the correct result.
4. Reset mid-block: drop rst_n after 2 BUSY cycles -> outputs immediately take reset values; after release, a fresh block of 16 bytes 0x7c gives 16 bytes 0x01 with no residue from the aborted block.
5. Round trip: 200 random states passed through the forward sbox (EN=1, NUM=16), then this block with LANES in {1,4,16} -> output equals the original; measured latency equals CHUNKS each time.
